// File: rtl/alu_seq_ctrl.sv
// Sequencer for the ALU/register-file datapath. It accepts RV32I R-type words
// and walks the datapath through read, execute and write-back phases.
module alu_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic [4:0]       r_addr_a,
  output logic [4:0]       r_addr_b,
  output logic [4:0]       w_addr,
  output logic [3:0]       alu_op,
  output logic             alu_strobe,
  output logic             w_en,
  input  logic [3:0]       flags,
  output logic [3:0]       flags_q,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic [4:0]       r_addr_a_q, r_addr_b_q, w_addr_q;
  logic [3:0]       alu_op_q;
  logic             alu_strobe_q, w_en_q, done_q, illegal_q;
  logic [3:0]       flags_cap_q;
  logic [CNT_W-1:0] retired_q;

  logic [6:0] funct7_d;
  logic [2:0] funct3_d;
  logic       legal_d;
  logic [3:0] alu_op_d;

  always_comb begin
    funct7_d = in_instr[31:25];
    funct3_d = in_instr[14:12];
    alu_op_d = {in_instr[30], in_instr[14:12]};
    legal_d  = (in_instr[6:0] == 7'b0110011) &&
               ((funct7_d == 7'b0000000) ||
                ((funct7_d == 7'b0100000) &&
                 ((funct3_d == 3'b000) || (funct3_d == 3'b101))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      r_addr_a_q   <= '0;
      r_addr_b_q   <= '0;
      w_addr_q     <= '0;
      alu_op_q     <= '0;
      alu_strobe_q <= 1'b0;
      w_en_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      flags_cap_q  <= '0;
      retired_q    <= '0;
    end else begin
      alu_strobe_q <= 1'b0;
      w_en_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (legal_d) begin
              r_addr_a_q <= in_instr[19:15];
              r_addr_b_q <= in_instr[24:20];
              w_addr_q   <= in_instr[11:7];
              alu_op_q   <= alu_op_d;
              state_q    <= READ;
            end else begin
              // Rejected words leave the datapath addresses untouched.
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
              state_q   <= ERR;
            end
          end
        end
        READ: begin
          alu_strobe_q <= 1'b1;
          state_q      <= EXEC;
        end
        EXEC: begin
          // x0 is hard-wired to zero, so it is never written.
          w_en_q  <= (w_addr_q != 5'd0);
          done_q  <= 1'b1;
          state_q <= WB;
        end
        WB: begin
          flags_cap_q <= flags;
          retired_q   <= retired_q + CNT_W'(1);
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        ERR: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign r_addr_a   = r_addr_a_q;
  assign r_addr_b   = r_addr_b_q;
  assign w_addr     = w_addr_q;
  assign alu_op     = alu_op_q;
  assign alu_strobe = alu_strobe_q;
  assign w_en       = w_en_q;
  assign flags_q    = flags_cap_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a 2-bit retired counter so wrap is exercised.
module tb_alu_seq_ctrl;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [4:0]       r_addr_a, r_addr_b, w_addr;
  logic [3:0]       alu_op;
  logic             alu_strobe, w_en;
  logic [3:0]       flags;
  logic [3:0]       flags_q;
  logic             done, illegal;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  alu_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .w_addr(w_addr),
    .alu_op(alu_op), .alu_strobe(alu_strobe), .w_en(w_en),
    .flags(flags), .flags_q(flags_q),
    .done(done), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ret_exp();
    logic [31:0] v;
    v = 32'(exp_ret % (1 << CNT_W));
    return v;
  endfunction

  // Drive one legal word and check every phase; hold keeps in_valid asserted afterwards.
  task automatic run_legal(input string name, input logic [31:0] instr,
                           input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                           input logic [3:0] op, input logic [3:0] flg, input bit hold);
    in_valid = 1'b1;
    in_instr = instr;
    chk({name, ".ready_before"}, 32'(in_ready), 32'd1);
    tick();
    $display("accept %s instr=%08h", name, instr);
    chk({name, ".ra"}, 32'(r_addr_a), 32'(ra));
    chk({name, ".rb"}, 32'(r_addr_b), 32'(rb));
    chk({name, ".rd"}, 32'(w_addr), 32'(rd));
    chk({name, ".op"}, 32'(alu_op), 32'(op));
    chk({name, ".read_strobe"}, {30'd0, alu_strobe, w_en}, 32'd0);
    chk({name, ".read_ready"}, 32'(in_ready), 32'd0);
    if (!hold) in_valid = 1'b0;
    tick();
    chk({name, ".exec_strobe"}, 32'(alu_strobe), 32'd1);
    chk({name, ".exec_wen_done"}, {30'd0, w_en, done}, 32'd0);
    flags = flg;
    tick();
    chk({name, ".wb_wen"}, 32'(w_en), (rd != 5'd0) ? 32'd1 : 32'd0);
    chk({name, ".wb_done"}, {30'd0, done, illegal}, 32'd2);
    chk({name, ".wb_strobe"}, 32'(alu_strobe), 32'd0);
    chk({name, ".wb_retired"}, 32'(retired), ret_exp());
    tick();
    exp_ret++;
    chk({name, ".idle_retired"}, 32'(retired), ret_exp());
    chk({name, ".idle_flags"}, 32'(flags_q), 32'(flg));
    chk({name, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({name, ".idle_pulses"}, {28'd0, alu_strobe, w_en, done, illegal}, 32'd0);
    flags = 4'h0;
  endtask

  task automatic run_illegal(input string name, input logic [31:0] instr,
                             input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                             input logic [3:0] op);
    in_valid = 1'b1;
    in_instr = instr;
    tick();
    $display("accept %s instr=%08h (illegal)", name, instr);
    in_valid = 1'b0;
    chk({name, ".err_done_illegal"}, {30'd0, done, illegal}, 32'd3);
    chk({name, ".err_no_strobe"}, {30'd0, alu_strobe, w_en}, 32'd0);
    chk({name, ".err_addr_hold"}, {17'd0, r_addr_a, r_addr_b, w_addr}, {17'd0, ra, rb, rd});
    chk({name, ".err_op_hold"}, 32'(alu_op), 32'(op));
    chk({name, ".err_ready"}, 32'(in_ready), 32'd0);
    tick();
    chk({name, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({name, ".idle_pulses"}, {28'd0, alu_strobe, w_en, done, illegal}, 32'd0);
    chk({name, ".idle_retired"}, 32'(retired), ret_exp());
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    flags = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset.ready", 32'(in_ready), 32'd1);
    chk("reset.addr", {17'd0, r_addr_a, r_addr_b, w_addr}, 32'd0);
    chk("reset.op", 32'(alu_op), 32'd0);
    chk("reset.pulses", {28'd0, alu_strobe, w_en, done, illegal}, 32'd0);
    chk("reset.flags_q", 32'(flags_q), 32'd0);
    chk("reset.retired", 32'(retired), 32'd0);

    run_legal("add_x3", 32'h002081B3, 5'd1, 5'd2, 5'd3, 4'b0000, 4'b0101, 1'b0);
    run_legal("sub_x5", 32'h407302B3, 5'd6, 5'd7, 5'd5, 4'b1000, 4'b0011, 1'b1);
    run_legal("sra_x8", 32'h40A4D433, 5'd9, 5'd10, 5'd8, 4'b1101, 4'b1100, 1'b0);
    run_legal("add_x0", 32'h00208033, 5'd1, 5'd2, 5'd0, 4'b0000, 4'b0001, 1'b0);

    run_illegal("addi", 32'h00000013, 5'd1, 5'd2, 5'd0, 4'b0000);
    run_illegal("f7_f3_001", 32'h40209033, 5'd1, 5'd2, 5'd0, 4'b0000);

    // Reset while the word sits in EXEC: the pending write must be dropped.
    in_valid = 1'b1;
    in_instr = 32'h407302B3;
    tick();
    in_valid = 1'b0;
    tick();
    $display("reset asserted in EXEC");
    chk("rst_exec.in_exec", 32'(alu_strobe), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ret = 0;
    chk("rst_exec.wen", 32'(w_en), 32'd0);
    chk("rst_exec.pulses", {28'd0, alu_strobe, w_en, done, illegal}, 32'd0);
    chk("rst_exec.addr", {17'd0, r_addr_a, r_addr_b, w_addr}, 32'd0);
    chk("rst_exec.op_flags", {24'd0, alu_op, flags_q}, 32'd0);
    chk("rst_exec.ready", 32'(in_ready), 32'd1);
    chk("rst_exec.retired", 32'(retired), 32'd0);
    tick();
    chk("rst_exec.wen_later", {30'd0, w_en, done}, 32'd0);

    // Five legal words wrap a 2-bit counter: 1,2,3,0,1.
    run_legal("wrap1", 32'h002081B3, 5'd1, 5'd2, 5'd3, 4'b0000, 4'b0000, 1'b0);
    run_legal("wrap2", 32'h407302B3, 5'd6, 5'd7, 5'd5, 4'b1000, 4'b0110, 1'b0);
    run_legal("wrap3", 32'h40A4D433, 5'd9, 5'd10, 5'd8, 4'b1101, 4'b0001, 1'b0);
    run_legal("wrap4", 32'h00208033, 5'd1, 5'd2, 5'd0, 4'b0000, 4'b1111, 1'b0);
    run_legal("wrap5", 32'h002081B3, 5'd1, 5'd2, 5'd3, 4'b0000, 4'b1010, 1'b0);
    chk("wrap.final_retired", 32'(retired), 32'd1);
    chk("wrap.final_flags", 32'(flags_q), 32'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
